// File: rtl/beer_slide_ctrl.sv
// beer_slide_ctrl: beer-mug motion engine. P1 throws a mug from its row, the mug
// slides right STEP pixels per game tick until it reaches X_END, and it is then
// scored as caught or missed against P2's row. The mug stays visible for
// HOLD_TICKS ticks before it disappears.
//
// Optional feature macro: BEER_SPEEDUP_EN. When defined, the step grows by one
// every fourth catch, up to STEP_MAX.
//
// Ports
//   CLK100MHZ    in   1   system clock
//   RESET        in   1   synchronous, active-low reset
//   tick         in   1   one-cycle game-tick pulse
//   fire         in   1   P1 throw key (level); only its rising edge launches
//   P1_y         in  11   P1 sprite top row, sampled at launch
//   P2_y         in  11   P2 sprite top row, sampled at arrival
//   beer_x       out 11   mug left column
//   beer_y       out 11   mug top row
//   beer_active  out  1   mug drawn
//   caught       out  1   one-cycle pulse: arrival within CATCH_WIN
//   missed       out  1   one-cycle pulse: arrival outside CATCH_WIN
//   served_cnt   out  8   catch count, saturating
//   miss_cnt     out  8   miss count, saturating
module beer_slide_ctrl #(
    parameter int unsigned X_START    = 40,
    parameter int unsigned X_END      = 580,
    parameter int unsigned STEP       = 4,
    parameter int unsigned CATCH_WIN  = 20,
`ifdef BEER_SPEEDUP_EN
    parameter int unsigned STEP_MAX   = 12,
`endif
    parameter int unsigned HOLD_TICKS = 8
) (
    input  logic        CLK100MHZ,
    input  logic        RESET,
    input  logic        tick,
    input  logic        fire,
    input  logic [10:0] P1_y,
    input  logic [10:0] P2_y,
    output logic [10:0] beer_x,
    output logic [10:0] beer_y,
    output logic        beer_active,
    output logic        caught,
    output logic        missed,
    output logic [7:0]  served_cnt,
    output logic [7:0]  miss_cnt
);

    localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SLIDE = 2'd1;
    localparam logic [1:0] S_JUDGE = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              fire_q;
    logic [10:0]       beer_x_q, beer_x_d;
    logic [10:0]       beer_y_q, beer_y_d;
    logic              active_q, active_d;
    logic              caught_q, caught_d;
    logic              missed_q, missed_d;
    logic [7:0]        served_q, served_d;
    logic [7:0]        miss_q, miss_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [11:0]       step_c;

    logic              launch_c;
    logic [11:0]       sum_c;
    logic [11:0]       dist_c;
    logic [7:0]        served_inc_c;

`ifdef BEER_SPEEDUP_EN
    logic [11:0]       step_q, step_d;
    assign step_c = step_q;
`else
    assign step_c = 12'(STEP);
`endif

    // Rising edge of the throw key; holding it does not repeat.
    assign launch_c = fire & ~fire_q;

    // 12-bit add so an X_END near the 11-bit limit cannot wrap.
    assign sum_c = {1'b0, beer_x_q} + step_c;

    // Row distance between mug and P2, unsigned 12-bit.
    assign dist_c = ({1'b0, beer_y_q} >= {1'b0, P2_y}) ? ({1'b0, beer_y_q} - {1'b0, P2_y})
                                                       : ({1'b0, P2_y} - {1'b0, beer_y_q});

    assign served_inc_c = served_q + 8'd1;

    // Next-state and datapath logic.
    always_comb begin
        state_d  = state_q;
        beer_x_d = beer_x_q;
        beer_y_d = beer_y_q;
        active_d = active_q;
        caught_d = 1'b0;
        missed_d = 1'b0;
        served_d = served_q;
        miss_d   = miss_q;
        hold_d   = hold_q;
`ifdef BEER_SPEEDUP_EN
        step_d   = step_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (launch_c) begin
                    beer_x_d = 11'(X_START);
                    beer_y_d = P1_y;
                    active_d = 1'b1;
                    state_d  = S_SLIDE;
                end
            end
            S_SLIDE: begin
                if (tick) begin
                    if (sum_c >= 12'(X_END)) begin
                        beer_x_d = 11'(X_END);
                        state_d  = S_JUDGE;
                    end else begin
                        beer_x_d = sum_c[10:0];
                    end
                end
            end
            S_JUDGE: begin
                if (dist_c <= 12'(CATCH_WIN)) begin
                    caught_d = 1'b1;
                    if (served_q != 8'hFF) begin
                        served_d = served_inc_c;
`ifdef BEER_SPEEDUP_EN
                        // Speed up each time the catch count lands on a multiple of four.
                        if ((served_inc_c[1:0] == 2'b00) && (step_q < 12'(STEP_MAX))) begin
                            step_d = step_q + 12'd1;
                        end
`endif
                    end
                end else begin
                    missed_d = 1'b1;
                    if (miss_q != 8'hFF) begin
                        miss_d = miss_q + 8'd1;
                    end
                end
                hold_d  = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (tick) begin
                    if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
                        active_d = 1'b0;
                        beer_x_d = 11'(X_START);
                        state_d  = S_IDLE;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK100MHZ) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            fire_q   <= 1'b0;
            beer_x_q <= 11'(X_START);
            beer_y_q <= '0;
            active_q <= 1'b0;
            caught_q <= 1'b0;
            missed_q <= 1'b0;
            served_q <= '0;
            miss_q   <= '0;
            hold_q   <= '0;
`ifdef BEER_SPEEDUP_EN
            step_q   <= 12'(STEP);
`endif
        end else begin
            state_q  <= state_d;
            fire_q   <= fire;
            beer_x_q <= beer_x_d;
            beer_y_q <= beer_y_d;
            active_q <= active_d;
            caught_q <= caught_d;
            missed_q <= missed_d;
            served_q <= served_d;
            miss_q   <= miss_d;
            hold_q   <= hold_d;
`ifdef BEER_SPEEDUP_EN
            step_q   <= step_d;
`endif
        end
    end

    assign beer_x      = beer_x_q;
    assign beer_y      = beer_y_q;
    assign beer_active = active_q;
    assign caught      = caught_q;
    assign missed      = missed_q;
    assign served_cnt  = served_q;
    assign miss_cnt    = miss_q;

endmodule

// File: tb/tb_beer_slide_ctrl.sv
// Testbench for beer_slide_ctrl: random throws scored against a reference model.
module tb_beer_slide_ctrl;

    localparam int XS   = 40;
    localparam int XE   = 580;
    localparam int STP  = 4;
    localparam int WIN  = 20;
    localparam int HOLD = 8;
    localparam int SMAX = 12;

    logic        CLK100MHZ;
    logic        RESET;
    logic        tick;
    logic        fire;
    logic [10:0] P1_y;
    logic [10:0] P2_y;
    logic [10:0] beer_x;
    logic [10:0] beer_y;
    logic        beer_active;
    logic        caught;
    logic        missed;
    logic [7:0]  served_cnt;
    logic [7:0]  miss_cnt;

    beer_slide_ctrl dut (
        .CLK100MHZ  (CLK100MHZ),
        .RESET      (RESET),
        .tick       (tick),
        .fire       (fire),
        .P1_y       (P1_y),
        .P2_y       (P2_y),
        .beer_x     (beer_x),
        .beer_y     (beer_y),
        .beer_active(beer_active),
        .caught     (caught),
        .missed     (missed),
        .served_cnt (served_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    typedef struct {
        bit c;
        int served;
        int miss;
        int y;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   m_served = 0;
    int   m_miss   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_step();
        int s;
        s = STP;
`ifdef BEER_SPEEDUP_EN
        s = STP + m_served / 4;
        if (s > SMAX) s = SMAX;
`endif
        return s;
    endfunction

    function automatic int pick_p2(input int p1, input int off);
        if (p1 + off <= 2047) return p1 + off;
        return p1 - off;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK100MHZ);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge CLK100MHZ);
        tick = 1'b0;
    endtask

    // Score monitor: every caught/missed pulse must match the oldest expected arrival.
    always @(negedge CLK100MHZ) begin
        if (caught || missed) begin
            chk("pulse_exclusive", int'(caught && missed), 0);
            if (sb.size() == 0) begin
                chk("spurious_pulse", int'(caught) + int'(missed), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("caught_flag", int'(caught), int'(e.c));
                chk("missed_flag", int'(missed), int'(!e.c));
                chk("served_cnt", int'(served_cnt), e.served);
                chk("miss_cnt", int'(miss_cnt), e.miss);
                chk("judge_y", int'(beer_y), e.y);
                chk("judge_x", int'(beer_x), XE);
            end
        end
    end

    // One full throw: launch, slide, arrival, hold.
    task automatic throw(input int p1, input int p2, input bit tick_with_fire, input bit refire);
        int  s, k, xe, d;
        bit  arrived;
        exp_t e;
        s = model_step();
        P1_y = 11'(p1);
        P2_y = 11'(p2);
        fire = 1'b1;
        tick = tick_with_fire;
        @(negedge CLK100MHZ);
        tick = 1'b0;
        chk("launch_active", int'(beer_active), 1);
        chk("launch_x", int'(beer_x), XS);
        chk("launch_y", int'(beer_y), p1);
        k = 0;
        arrived = 1'b0;
        while (!arrived && k < 1000) begin
            fire = (k < 3) || (refire && k >= 20 && k < 25);
            P1_y = 11'($urandom_range(0, 2047));
            cyc($urandom_range(0, 2));
            k++;
            xe = XS + k * s;
            if (xe >= XE) begin
                xe = XE;
                arrived = 1'b1;
                d = (p1 >= p2) ? p1 - p2 : p2 - p1;
                e.c = (d <= WIN);
                if (e.c && m_served < 255) m_served++;
                if (!e.c && m_miss < 255) m_miss++;
                e.served = m_served;
                e.miss = m_miss;
                e.y = p1;
                sb.push_back(e);
            end
            do_tick();
            chk("slide_x", int'(beer_x), xe);
            chk("slide_y", int'(beer_y), p1);
        end
        chk("arrival_bound", int'(arrived), 1);
        fire = 1'b0;
        cyc(2);
        for (int h = 1; h <= HOLD; h++) begin
            cyc($urandom_range(0, 2));
            do_tick();
            chk("hold_active", int'(beer_active), (h < HOLD) ? 1 : 0);
        end
        chk("idle_x", int'(beer_x), XS);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int p1, p2, mode, n_extra;
        RESET = 1'b0;
        tick  = 1'b0;
        fire  = 1'b0;
        P1_y  = 11'd0;
        P2_y  = 11'd0;

        // Reset held three cycles with tick/fire activity.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK100MHZ);
            fire = ~fire;
            tick = 1'b1;
            P1_y = 11'd123;
        end
        @(negedge CLK100MHZ);
        chk("rst_active", int'(beer_active), 0);
        chk("rst_x", int'(beer_x), XS);
        chk("rst_y", int'(beer_y), 0);
        chk("rst_served", int'(served_cnt), 0);
        chk("rst_miss", int'(miss_cnt), 0);
        chk("rst_pulses", int'(caught) + int'(missed), 0);
        tick = 1'b0;
        fire = 1'b0;
        cyc(2);
        RESET = 1'b1;
        cyc(2);

        // Ticks while idle move nothing.
        do_tick();
        do_tick();
        chk("idle_tick_x", int'(beer_x), XS);
        chk("idle_tick_active", int'(beer_active), 0);

        // Directed throws: catch, miss with re-press, launch+tick, window edges.
        throw(100, 110, 1'b0, 1'b0);
        throw(100, 200, 1'b0, 1'b1);
        throw(500, 480, 1'b1, 1'b0);
        throw(0, 20, 1'b0, 1'b0);
        throw(2047, 2026, 1'b0, 1'b1);

        // Random throws.
        for (int t = 0; t < 8; t++) begin
            p1 = $urandom_range(0, 2047);
            mode = $urandom_range(0, 4);
            case (mode)
                0: p2 = p1;
                1: p2 = pick_p2(p1, $urandom_range(0, 20));
                2: p2 = pick_p2(p1, 21);
                3: p2 = pick_p2(p1, $urandom_range(22, 300));
                default: p2 = $urandom_range(0, 2047);
            endcase
            throw(p1, p2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef BEER_SPEEDUP_EN
        n_extra = 36 - m_served;
        for (int t = 0; t < n_extra; t++) begin
            p1 = $urandom_range(0, 2047);
            throw(p1, pick_p2(p1, $urandom_range(0, 20)), 1'b0, 1'b0);
        end
`else
        n_extra = 0;
`endif

        // Reset mid-slide at beer_x==300: abort with no score pulse.
        P1_y = 11'd300;
        P2_y = 11'd300;
        fire = 1'b1;
        @(negedge CLK100MHZ);
        fire = 1'b0;
        begin
            int k, s;
            s = model_step();
            k = 0;
            while (XS + k * s < 300 && k < 1000) begin
                k++;
                do_tick();
            end
            chk("pre_reset_x", int'(beer_x), XS + k * s);
        end
        RESET = 1'b0;
        @(negedge CLK100MHZ);
        RESET = 1'b1;
        m_served = 0;
        m_miss = 0;
        chk("abort_active", int'(beer_active), 0);
        chk("abort_x", int'(beer_x), XS);
        chk("abort_served", int'(served_cnt), 0);
        chk("abort_miss", int'(miss_cnt), 0);
        cyc(4);
        do_tick();
        chk("abort_idle_x", int'(beer_x), XS);

        // A throw after the abort still scores from zero.
        throw(700, 715, 1'b0, 1'b0);
        chk("final_served", int'(served_cnt), m_served);
        chk("final_sb", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog against a hung run.
    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
